// File: rtl/dcache_unit.sv
// Direct-mapped write-back, write-allocate data cache with burst refill and dirty-line writeback.
// Hits complete combinationally in the same cycle; a miss holds cpu_ready low until the line is installed.
module dcache_unit #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic                  cpu_ren,
    input  logic                  cpu_wen,
    input  logic [DATA_W/8-1:0]   cpu_be,
    input  logic [DATA_W-1:0]     cpu_wdata,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  cpu_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int BE_W  = DATA_W / 8;
    localparam int BO_W  = $clog2(BE_W);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - BO_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);
    localparam logic [BO_W-1:0]  BO_ZERO   = '0;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, INSTALL} state_t;

    state_t              state_q;
    logic [OFF_W-1:0]    beat_q;
    logic [31:0]         hit_count_q, hit_count_d;
    logic [31:0]         miss_count_q, miss_count_d;

    logic                valid_q [SETS];
    logic                dirty_q [SETS];
    logic [TAG_W-1:0]    tag_q   [SETS];
    logic [DATA_W-1:0]   data_q  [SETS][LINE_WORDS];
    logic [DATA_W-1:0]   lbuf_q  [LINE_WORDS];

    logic [OFF_W-1:0]    req_off;
    logic [IDX_W-1:0]    req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [OFF_W-1:0]    beat_nxt;
    logic                req, hit, idle, acc_hit, store_hit, miss_start, install;
    logic                unused_addr_bits;

    assign req_off  = cpu_addr[BO_W +: OFF_W];
    assign req_idx  = cpu_addr[BO_W + OFF_W +: IDX_W];
    assign req_tag  = cpu_addr[ADDR_W-1 -: TAG_W];
    assign beat_nxt = beat_q + OFF_W'(1);
    assign unused_addr_bits = ^cpu_addr[BO_W-1:0];

    assign req        = cpu_ren | cpu_wen;
    assign idle       = (state_q == IDLE);
    assign hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign acc_hit    = idle && req && hit;
    assign store_hit  = acc_hit && cpu_wen;
    assign miss_start = idle && req && !hit;
    assign install    = (state_q == INSTALL);

    assign cpu_ready  = idle && (!req || hit);
    assign cpu_rdata  = (idle && cpu_ren && hit) ? data_q[req_idx][req_off] : '0;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (acc_hit && hit_count_q != 32'hFFFF_FFFF)
            hit_count_d = hit_count_q + 32'd1;
        if (miss_start && miss_count_q != 32'hFFFF_FFFF)
            miss_count_d = miss_count_q + 32'd1;
    end

    function automatic logic [ADDR_W-1:0] beat_addr(input logic [TAG_W-1:0] t,
                                                     input logic [IDX_W-1:0] i,
                                                     input logic [OFF_W-1:0] b);
        return {t, i, b, BO_ZERO};
    endfunction

    // Memory-side outputs are registered so address/data only move on the edge after an ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            case (state_q)
                IDLE: begin
                    if (miss_start) begin
                        beat_q  <= '0;
                        mem_req <= 1'b1;
                        if (valid_q[req_idx] && dirty_q[req_idx]) begin
                            state_q   <= WRITEBACK;
                            mem_we    <= 1'b1;
                            mem_addr  <= beat_addr(tag_q[req_idx], req_idx, '0);
                            mem_wdata <= data_q[req_idx][0];
                        end else begin
                            state_q   <= REFILL;
                            mem_we    <= 1'b0;
                            mem_addr  <= beat_addr(req_tag, req_idx, '0);
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        if (beat_q == LAST_BEAT) begin
                            state_q   <= REFILL;
                            beat_q    <= '0;
                            mem_we    <= 1'b0;
                            mem_addr  <= beat_addr(req_tag, req_idx, '0);
                            mem_wdata <= '0;
                        end else begin
                            beat_q    <= beat_nxt;
                            mem_addr  <= beat_addr(tag_q[req_idx], req_idx, beat_nxt);
                            mem_wdata <= data_q[req_idx][beat_nxt];
                        end
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        if (beat_q == LAST_BEAT) begin
                            state_q <= INSTALL;
                            mem_req <= 1'b0;
                        end else begin
                            beat_q   <= beat_nxt;
                            mem_addr <= beat_addr(req_tag, req_idx, beat_nxt);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == REFILL && mem_ack)
            lbuf_q[beat_q] <= mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (install) begin
            tag_q[req_idx] <= req_tag;
            for (int w = 0; w < LINE_WORDS; w++)
                data_q[req_idx][w] <= lbuf_q[w];
        end else if (store_hit) begin
            for (int b = 0; b < BE_W; b++)
                if (cpu_be[b])
                    data_q[req_idx][req_off][8*b +: 8] <= cpu_wdata[8*b +: 8];
        end
    end

    // A store hit marks the line dirty even with no byte lanes enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= 1'b0;
                dirty_q[s] <= 1'b0;
            end
        end else if (install) begin
            valid_q[req_idx] <= 1'b1;
            dirty_q[req_idx] <= 1'b0;
        end else if (store_hit) begin
            dirty_q[req_idx] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dcache_unit.sv
// Scoreboard bench for dcache_unit: expected memory beats and load data are queued by the
// stimulus and consumed by a monitor that also models the handshaked memory.
module tb_dcache_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cpu_addr = '0;
    logic        cpu_ren = 1'b0;
    logic        cpu_wen = 1'b0;
    logic [3:0]  cpu_be = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    dcache_unit #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4), .SETS(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_ren(cpu_ren), .cpu_wen(cpu_wen),
        .cpu_be(cpu_be), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    beat_t       exp_beats[$];
    logic [31:0] exp_loads[$];
    logic [31:0] mem_model[logic [31:0]];
    int          tests = 0;
    int          fails = 0;
    int          ack_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got event, expected none at %0t", name, $time);
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return 32'hDEAD_0000 | a;
    endfunction

    task automatic push_reads(input logic [31:0] base);
        for (int i = 0; i < 4; i++) exp_beats.push_back('{1'b0, base + 32'(4*i), 32'h0});
    endtask

    task automatic push_write(input logic [31:0] a, input logic [31:0] d);
        exp_beats.push_back('{1'b1, a, d});
    endtask

    // Monitor plus memory responder: a beat is checked at the moment its ack is raised.
    always @(negedge clk) begin
        if (!reset && cpu_ready && cpu_ren && !cpu_wen) begin
            if (exp_loads.size() == 0) fail_now("unexpected_load");
            else chk("load_data", cpu_rdata, exp_loads.pop_front());
        end
        if (reset || !mem_req) begin
            mem_ack = 1'b0;
            ack_cnt = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
            ack_cnt = 0;
        end else if (ack_cnt == 0) begin
            ack_cnt = 1;
        end else begin
            beat_t b;
            mem_ack = 1'b1;
            ack_cnt = 0;
            if (exp_beats.size() == 0) fail_now("unexpected_beat");
            else begin
                b = exp_beats.pop_front();
                chk("beat_we", {31'h0, mem_we}, {31'h0, b.we});
                chk("beat_addr", mem_addr, b.addr);
                if (b.we) chk("beat_wdata", mem_wdata, b.data);
            end
            if (mem_we) mem_model[mem_addr] = mem_wdata;
            else mem_rdata = mem_read(mem_addr);
        end
    end

    task automatic access(input logic ren, input logic wen, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd, output int stall);
        bit done = 1'b0;
        cpu_addr = a; cpu_ren = ren; cpu_wen = wen; cpu_be = be; cpu_wdata = wd;
        stall = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (cpu_ready) done = 1'b1;
            else stall++;
        end
        if (!done) fail_now("access_timeout");
        @(posedge clk);
        #1;
        cpu_ren = 1'b0; cpu_wen = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  st;
        bit  found;
        for (int i = 0; i < 4; i++) begin
            mem_model[32'h10 + 32'(4*i)] = 32'hA0 + 32'(i);
            mem_model[32'h50 + 32'(4*i)] = 32'hB0 + 32'(i);
            mem_model[32'h20 + 32'(4*i)] = 32'hC0 + 32'(i);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, cpu_ready}, 32'h1);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        reset = 1'b0;
        #1;
        chk("rst_hits", hit_count, 32'h0);
        chk("rst_misses", miss_count, 32'h0);

        // Clean miss: four read beats, install, then the held load hits.
        push_reads(32'h10);
        exp_loads.push_back(32'hA0);
        access(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, st);
        chk("clean_miss_stall", 32'(st), 32'd13);
        chk("miss1_misses", miss_count, 32'd1);
        chk("miss1_hits", hit_count, 32'd1);

        exp_loads.push_back(32'hA2);
        access(1'b1, 1'b0, 32'h18, 4'h0, 32'h0, st);
        chk("hit_load_stall", 32'(st), 32'd0);
        chk("hit_no_mem_req", {31'h0, mem_req}, 32'h0);

        access(1'b0, 1'b1, 32'h14, 4'b0011, 32'hFFFF_1234, st);
        chk("store_hit_stall", 32'(st), 32'd0);
        chk("store_no_rdata", cpu_rdata, 32'h0);

        exp_loads.push_back(32'h0000_1234);
        access(1'b1, 1'b0, 32'h14, 4'h0, 32'h0, st);
        chk("hits_after_4", hit_count, 32'd4);

        // Conflict on a dirty line: writeback of the old line, then refill.
        push_write(32'h10, 32'hA0);
        push_write(32'h14, 32'h0000_1234);
        push_write(32'h18, 32'hA2);
        push_write(32'h1C, 32'hA3);
        push_reads(32'h50);
        exp_loads.push_back(32'hB0);
        access(1'b1, 1'b0, 32'h50, 4'h0, 32'h0, st);
        chk("dirty_miss_stall", 32'(st), 32'd25);
        chk("miss2_misses", miss_count, 32'd2);
        chk("miss2_hits", hit_count, 32'd5);
        chk("wb_mem_0x14", mem_model[32'h14], 32'h0000_1234);

        // Load and store together on a hit behaves as a store.
        access(1'b1, 1'b1, 32'h54, 4'b1111, 32'hCAFE_0001, st);
        chk("ren_wen_stall", 32'(st), 32'd0);
        exp_loads.push_back(32'hCAFE_0001);
        access(1'b1, 1'b0, 32'h54, 4'h0, 32'h0, st);
        chk("hits_after_7", hit_count, 32'd7);

        // Reset while refill beat 2 is outstanding.
        push_reads(32'h20);
        void'(exp_beats.pop_back());
        void'(exp_beats.pop_back());
        cpu_addr = 32'h20; cpu_ren = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #1;
            if (mem_req && mem_addr == 32'h28) found = 1'b1;
        end
        chk("reached_refill_beat2", {31'h0, found}, 32'h1);
        reset = 1'b1;
        cpu_ren = 1'b0;
        #1;
        chk("midreset_mem_req", {31'h0, mem_req}, 32'h0);
        chk("midreset_hits", hit_count, 32'h0);
        chk("midreset_misses", miss_count, 32'h0);
        chk("midreset_ready", {31'h0, cpu_ready}, 32'h1);
        chk("midreset_beats_left", 32'(exp_beats.size()), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Dirty data in the cache was lost; the line comes back from memory.
        push_reads(32'h50);
        exp_loads.push_back(32'hB1);
        access(1'b1, 1'b0, 32'h54, 4'h0, 32'h0, st);
        chk("post_reset_stall", 32'(st), 32'd13);
        chk("post_reset_misses", miss_count, 32'd1);
        chk("post_reset_hits", hit_count, 32'd1);

        repeat (4) @(posedge clk);
        #1;
        chk("beats_drained", 32'(exp_beats.size()), 32'h0);
        chk("loads_drained", 32'(exp_loads.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
